ltc2333_read: RTL

Receive-side companion to the LTC2333 write/control block. It oversamples the ADC's echoed serial clock (scko) and data (sdo) in the fabric clock domain and deserialises each 24-bit per-channel frame into result, channel ID and SoftSpan fields. Decoded words go out on an AXI-Stream master through a small FIFO, with tlast marking the end of each conversion frame. It sits between the LTC2333 pins and the DMA/histogramming stream.

---
 rtl/ltc2333_read_pkg.sv | 30 +++
 rtl/ltc2333_read_if.sv | 12 +
 rtl/ltc2333_read_fifo.sv | 46 ++++
 rtl/ltc2333_read.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ltc2333_read_pkg.sv
// Shared types and constants for the LTC2333 receive path.
package ltc2333_pkg;

  localparam int FRAME_BITS = 24;
  localparam int RESULT_W   = 18;
  localparam int CHAN_W     = 3;
  localparam int SPAN_W     = 3;
  localparam int SEQ_W      = 8;

  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic [SPAN_W-1:0]   span;
    logic [CHAN_W-1:0]   chan;
    logic [RESULT_W-1:0] result;
  } ltc2333_word_t;

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} rd_state_t;

  // Splits a raw MSB-first frame into result / channel / SoftSpan fields.
  function automatic ltc2333_word_t decode_frame(input logic [FRAME_BITS-1:0] bits,
                                                 input logic [SEQ_W-1:0] seq);
    ltc2333_word_t w;
    w.result = bits[FRAME_BITS-1 -: RESULT_W];
    w.chan   = bits[SPAN_W +: CHAN_W];
    w.span   = bits[SPAN_W-1:0];
    w.seq    = seq;
    return w;
  endfunction

endpackage

// File: rtl/ltc2333_read_if.sv
// AXI-Stream bundle carrying decoded LTC2333 words.
interface ltc2333_read_if;
  import ltc2333_pkg::*;

  logic [$bits(ltc2333_word_t)-1:0] tdata;
  logic                             tvalid;
  logic                             tready;
  logic                             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ltc2333_read_fifo.sv
// First-word-fall-through FIFO; DEPTH must be a power of 2 and at least 4.
module ltc2333_read_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ltc2333_read.sv
// LTC2333 serial readback: oversamples scko/sdo, decodes 24-bit frames, streams them out.
// Define LTC2333_READ_SEQ_EN to carry a per-frame sequence number in tdata[31:24].
module ltc2333_read
  import ltc2333_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [3:0]            words_per_frame,
  input  logic                  cnv,
  input  logic                  scko,
  input  logic                  sdo,
  ltc2333_read_if.master        m_axis,
  output logic                  frame_err,
  output logic                  overflow,
  output logic [15:0]           err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  rd_state_t             state, state_n;
  logic [2:0]            scko_sync;
  logic [1:0]            sdo_sync;
  logic [2:0]            cnv_sync;
  logic                  scko_rise, cnv_rise;
  logic [FRAME_BITS-1:0] sr, sr_n;
  logic [4:0]            bit_cnt;
  logic [3:0]            word_cnt, wpf;
  logic [TW-1:0]         timer;
  logic                  timeout, start, abort, shift_en, word_done, last_word;
  logic [SEQ_W-1:0]      cur_seq;
  logic                  push_q, push_last_q;
  ltc2333_word_t         push_word_q;
  logic [32:0]           fifo_head;
  logic                  fifo_full, fifo_empty, fifo_drop;

  assign scko_rise = scko_sync[1] & ~scko_sync[2];
  assign cnv_rise  = cnv_sync[1] & ~cnv_sync[2];
  assign sr_n      = {sr[FRAME_BITS-2:0], sdo_sync[1]};
  assign last_word = ((word_cnt + 4'd1) == wpf);
  assign timeout   = (state != IDLE) && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wpf = words_per_frame;
    if (words_per_frame == 4'd0)     wpf = 4'd1;
    else if (words_per_frame > 4'd8) wpf = 4'd8;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      scko_sync <= '0;
      sdo_sync  <= '0;
      cnv_sync  <= '0;
      state     <= IDLE;
    end else begin
      scko_sync <= {scko_sync[1:0], scko};
      sdo_sync  <= {sdo_sync[0], sdo};
      cnv_sync  <= {cnv_sync[1:0], cnv};
      state     <= state_n;
    end
  end

  // Abort (cnv or timeout) takes priority over a coincident scko edge.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    abort     = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (cnv_rise && enable) begin
          start   = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED, SHIFT: begin
        if (cnv_rise || timeout) begin
          abort   = 1'b1;
          state_n = (cnv_rise && enable) ? ARMED : IDLE;
        end else if (scko_rise) begin
          shift_en = 1'b1;
          state_n  = SHIFT;
          if (bit_cnt == LAST_BIT) begin
            word_done = 1'b1;
            if (last_word) state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sr          <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      timer       <= '0;
      push_q      <= 1'b0;
      push_last_q <= 1'b0;
      push_word_q <= '0;
    end else begin
      if (start || abort) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (shift_en) begin
        sr <= sr_n;
        if (word_done) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 4'd1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (state == IDLE || abort || scko_rise) timer <= '0;
      else if (!timeout)                       timer <= timer + TW'(1);
      push_q      <= word_done;
      push_last_q <= word_done && last_word;
      push_word_q <= decode_frame(sr_n, cur_seq);
    end
  end

`ifdef LTC2333_READ_SEQ_EN
  logic [SEQ_W-1:0] seq;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                    seq <= '0;
    else if (word_done && last_word) seq <= seq + 1'b1;
  end

  assign cur_seq = seq;
`else
  assign cur_seq = '0;
`endif

  // A dropped tlast word loses the frame boundary, so it is counted like an abort.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= abort;
      overflow  <= fifo_drop;
      if ((abort || (fifo_drop && push_last_q)) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  ltc2333_read_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(33)) u_fifo (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (push_q),
    .push_data ({push_last_q, push_word_q}),
    .pop       (m_axis.tready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_head[31:0];
  assign m_axis.tlast  = fifo_head[32];

endmodule
